vai_tx_rr_arb: RTL
==================

VAI_TX_RR_ARB -- requirements
Module: vai_tx_rr_arb

Interface
REQ-001 Parameter NUM_REQ, default 16: number of requesters (sub-AFU Tx sources); legal range 2..64.
REQ-002 Parameter DATA_WIDTH, default 64: width of one request packet.
REQ-003 Parameter FIFO_DEPTH, default 8: entries per requester FIFO; power of two, at least 4.
REQ-004 Parameter ALMFULL_SLACK, default 4: free entries remaining when in_almfull asserts; at least 1 and below FIFO_DEPTH.
REQ-005 Port pClk, input, 1: the single clock; all state on its rising edge.
REQ-006 Port SoftReset, input, 1: reset, synchronous and active-high.
REQ-007 Port in_valid, input, NUM_REQ: bit i is a packet strobe from requester i.
REQ-008 Port in_data, input, NUM_REQ*DATA_WIDTH: requester i packet at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 Port in_almfull, output, NUM_REQ: per-requester backpressure.
REQ-010 Port req_flush, input, NUM_REQ: per-requester flush from the manager's sub-AFU reset.
REQ-011 Port up_almfull, input, 1: upstream Tx almost-full.
REQ-012 Port out_valid, output, 1: upstream packet strobe.
REQ-013 Port out_data, output, DATA_WIDTH: upstream packet.
REQ-014 Port out_src, output, $clog2(NUM_REQ): index of the requester that issued out_data.
REQ-015 Port ovf_err, output, NUM_REQ: sticky per-requester overflow flag.

Function
REQ-016 Each requester SHALL own a FIFO_DEPTH-entry FIFO with a registered count of width $clog2(FIFO_DEPTH)+1 and wrapping read/write pointers.
REQ-017 Push i SHALL occur when in_valid[i]=1, req_flush[i]=0, and either count_i<FIFO_DEPTH or FIFO i is popped in the same cycle.
REQ-018 When in_valid[i]=1, count_i=FIFO_DEPTH, no pop and no flush, the packet SHALL be dropped, the count left unchanged and ovf_err[i] set to 1.
REQ-019 A simultaneous push and pop on one FIFO SHALL leave count_i unchanged and preserve FIFO order.
REQ-020 in_almfull[i] SHALL equal (count_i >= FIFO_DEPTH-ALMFULL_SLACK), decoded from registered count only.
REQ-021 Requester i SHALL be eligible in a cycle when count_i>0 and req_flush[i]=0.
REQ-022 Grant: when up_almfull=0 and any requester is eligible, the first eligible index searching cyclically from last_grant+1 (wrap NUM_REQ-1 to 0) SHALL be popped.
REQ-023 On the edge after a grant, out_valid SHALL be 1, out_data SHALL be the popped head entry, out_src SHALL be the granted index, and last_grant SHALL be the granted index.
REQ-024 With no grant (up_almfull=1 or none eligible), out_valid SHALL be 0, out_data and out_src SHALL hold their values, and last_grant SHALL be unchanged.
REQ-025 Throughput SHALL be at most one packet per cycle; no requester SHALL wait more than NUM_REQ-1 grants while eligible and up_almfull=0.
REQ-026 Latency: a push at edge t into an empty FIFO with no competition SHALL appear as out_valid=1 after edge t+2.
REQ-027 up_almfull SHALL be sampled combinationally in the grant cycle; asserting it in cycle c SHALL produce out_valid=0 after edge c.
REQ-028 A cycle with req_flush[i]=1 SHALL set count_i and both pointers to 0, clear ovf_err[i], ignore in_valid[i], and exclude i from the grant; a packet already registered on the outputs SHALL still be presented.

Reset
REQ-029 At SoftReset=1, the following SHALL take these values at the clock edge: all counts and pointers 0, out_valid 0, out_data 0, out_src 0, ovf_err 0, last_grant NUM_REQ-1.
REQ-030 During reset, in_valid SHALL be ignored, in_almfull SHALL read 0 from the cycle after the reset edge, and FIFO storage SHALL need no reset.
REQ-031 Reset during an active stream SHALL discard every queued packet; no stale packet SHALL appear after reset.

Verification
REQ-032 Single packet: requester 3 pushes 0xA5 at edge t, others idle -> out_valid=1, out_data=0xA5, out_src=3 after edge t+2, then out_valid=0.
REQ-033 Fairness: requesters 0, 1 and 5 each hold 4 entries, up_almfull=0, after reset -> out_src sequence 0,1,5,0,1,5,... across 12 consecutive out_valid cycles.
REQ-034 Backpressure: up_almfull=1 for 10 cycles with 3 entries queued -> out_valid=0 throughout, counts unchanged; on release, the 3 packets emerge in order on consecutive cycles.
REQ-035 Full/overflow (FIFO_DEPTH=8, ALMFULL_SLACK=4, up_almfull=1): 9 pushes to requester 2 -> in_almfull[2]=1 once count=4, 9th packet dropped, ovf_err[2]=1, count=8.
REQ-036 Flush mid-stream: requester 7 holds 5 entries, req_flush[7] pulsed for one cycle -> count_7=0, ovf_err[7]=0, no further out_src=7 packets; other requesters continue unaffected.
REQ-037 Reset mid-operation: SoftReset asserted with packets queued in 4 FIFOs -> the outputs match REQ-029 after the edge; out_valid stays 0 until new pushes occur.

Source files
------------

// File: rtl/vai_tx_rr_arb_if.sv
// Bundles the requester-facing and upstream-facing signals of the Tx round-robin arbiter.
// The master side drives requests and upstream backpressure; the slave side is the arbiter.
interface vai_tx_rr_arb_if #(
  parameter int unsigned NUM_REQ    = 16,
  parameter int unsigned DATA_WIDTH = 64
);
  localparam int unsigned SrcW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            in_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] in_data;
  logic [NUM_REQ-1:0]            in_almfull;
  logic [NUM_REQ-1:0]            req_flush;
  logic                          up_almfull;
  logic                          out_valid;
  logic [DATA_WIDTH-1:0]         out_data;
  logic [SrcW-1:0]               out_src;
  logic [NUM_REQ-1:0]            ovf_err;

  modport master (
    output in_valid, in_data, req_flush, up_almfull,
    input  in_almfull, out_valid, out_data, out_src, ovf_err
  );

  modport slave (
    input  in_valid, in_data, req_flush, up_almfull,
    output in_almfull, out_valid, out_data, out_src, ovf_err
  );
endinterface

// File: rtl/vai_tx_rr_arb.sv
// Per-requester FIFOs feeding one upstream Tx port through a round-robin arbiter.
// The grant is taken from registered FIFO counts and popped data is registered on the outputs.
module vai_tx_rr_arb #(
  parameter int unsigned NUM_REQ       = 16,
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned ALMFULL_SLACK = 4
) (
  input logic            pClk,
  input logic            SoftReset,
  vai_tx_rr_arb_if.slave tx_if
);
  localparam int unsigned SrcW = $clog2(NUM_REQ);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull  = CntW'(FIFO_DEPTH);
  localparam logic [CntW-1:0] AfThresh = CntW'(FIFO_DEPTH - ALMFULL_SLACK);

  logic [DATA_WIDTH-1:0] mem_q   [NUM_REQ][FIFO_DEPTH];
  logic [CntW-1:0]       count_q [NUM_REQ];
  logic [CntW-1:0]       count_d [NUM_REQ];
  logic [PtrW-1:0]       wptr_q  [NUM_REQ];
  logic [PtrW-1:0]       wptr_d  [NUM_REQ];
  logic [PtrW-1:0]       rptr_q  [NUM_REQ];
  logic [PtrW-1:0]       rptr_d  [NUM_REQ];
  logic [NUM_REQ-1:0]    ovf_q, ovf_d;
  logic [NUM_REQ-1:0]    elig, push, pop;

  logic [SrcW-1:0]       last_grant_q;
  logic [SrcW-1:0]       gnt_idx, cand;
  logic                  gnt_valid;
  int                    cand_full;

  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [SrcW-1:0]       out_src_q;

  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      elig[i] = (count_q[i] != '0) && !tx_if.req_flush[i];
    end
  end

  // Cyclic search starting just after the last winner.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = last_grant_q;
    cand      = '0;
    cand_full = 0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      cand_full = (int'(last_grant_q) + k) % int'(NUM_REQ);
      cand      = cand_full[SrcW-1:0];
      if (!gnt_valid && elig[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
    if (tx_if.up_almfull) begin
      gnt_valid = 1'b0;
    end
  end

  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      pop[i]  = gnt_valid && (gnt_idx == SrcW'(i));
      push[i] = tx_if.in_valid[i] && !tx_if.req_flush[i] && !SoftReset &&
                ((count_q[i] != CntFull) || (gnt_valid && (gnt_idx == SrcW'(i))));
    end
  end

  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      count_d[i] = count_q[i];
      wptr_d[i]  = wptr_q[i];
      rptr_d[i]  = rptr_q[i];
      ovf_d[i]   = ovf_q[i];
      if (tx_if.req_flush[i]) begin
        count_d[i] = '0;
        wptr_d[i]  = '0;
        rptr_d[i]  = '0;
        ovf_d[i]   = 1'b0;
      end else begin
        if (push[i]) wptr_d[i] = wptr_q[i] + 1'b1;
        if (pop[i])  rptr_d[i] = rptr_q[i] + 1'b1;
        if (push[i] && !pop[i]) begin
          count_d[i] = count_q[i] + 1'b1;
        end else if (!push[i] && pop[i]) begin
          count_d[i] = count_q[i] - 1'b1;
        end
        // A strobe that could not push means the FIFO was full with no pop.
        if (tx_if.in_valid[i] && !push[i]) ovf_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge pClk) begin
    if (SoftReset) begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        count_q[i] <= '0;
        wptr_q[i]  <= '0;
        rptr_q[i]  <= '0;
      end
      ovf_q        <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_src_q    <= '0;
      last_grant_q <= SrcW'(NUM_REQ - 1);
    end else begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        count_q[i] <= count_d[i];
        wptr_q[i]  <= wptr_d[i];
        rptr_q[i]  <= rptr_d[i];
      end
      ovf_q       <= ovf_d;
      out_valid_q <= gnt_valid;
      if (gnt_valid) begin
        out_data_q   <= mem_q[gnt_idx][rptr_q[gnt_idx]];
        out_src_q    <= gnt_idx;
        last_grant_q <= gnt_idx;
      end
    end
  end

  // Storage carries no reset; validity is tracked entirely by the counts.
  always_ff @(posedge pClk) begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (push[i]) begin
        mem_q[i][wptr_q[i]] <= tx_if.in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      tx_if.in_almfull[i] = (count_q[i] >= AfThresh);
    end
  end

  assign tx_if.out_valid = out_valid_q;
  assign tx_if.out_data  = out_data_q;
  assign tx_if.out_src   = out_src_q;
  assign tx_if.ovf_err   = ovf_q;

endmodule
